// File: rtl/serial_responder.sv
// serial_responder: byte-command register file (16 x 8) answering one response byte per frame.
module serial_responder #(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_stb,
  input  logic [7:0] rx_dat,
  input  logic       rx_err,
  output logic       rx_rdy,
  output logic       tx_stb,
  output logic [7:0] tx_dat,
  input  logic       tx_rdy,
  output logic [7:0] ctl
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_regs [16];
  logic [3:0]    r_addr;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_tx_dat, w_tx_dat;
  logic          w_acc, w_tmo, w_wr;
  assign rx_rdy = r_state != RESP;
  assign tx_stb = r_state == RESP;
  assign tx_dat = r_tx_dat;
  assign ctl    = r_regs[0];
  assign w_acc  = rx_stb & rx_rdy;
  assign w_tmo  = r_timer == TMAX;
  always_comb begin
    w_next   = r_state;
    w_tx_dat = r_tx_dat;
    w_wr     = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        if (rx_err || rx_dat[6:4] != 3'b000) begin
          w_next   = RESP;
          w_tx_dat = 8'hEE;
        end else if (rx_dat[7]) begin
          w_next = DATA;
        end else begin
          w_next   = RESP;
          w_tx_dat = r_regs[rx_dat[3:0]];
        end
      end
      // Timeout takes priority: a byte landing on the expiry cycle is dropped.
      DATA: if (w_tmo) begin
        w_next = IDLE;
      end else if (w_acc) begin
        w_next   = RESP;
        w_tx_dat = rx_err ? 8'hEE : 8'hAA;
        w_wr     = !rx_err;
      end
      RESP: if (tx_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_tx_dat <= '0;
      r_addr   <= '0;
      r_timer  <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state  <= w_next;
      r_tx_dat <= w_tx_dat;
      if (r_state == IDLE && w_acc) r_addr <= rx_dat[3:0];
      if (r_state != DATA) r_timer <= '0;
      else if (!w_acc && !w_tmo) r_timer <= r_timer + 1'b1;
      if (w_wr) r_regs[r_addr] <= rx_dat;
    end
  end
endmodule

// File: tb/tb_serial_responder.sv
// tb_serial_responder: scoreboard bench for serial_responder with TIMEOUT=100.
module tb_serial_responder;
  logic       clk = 0;
  logic       rst = 0;
  logic       rx_stb = 0;
  logic [7:0] rx_dat = 0;
  logic       rx_err = 0;
  logic       rx_rdy;
  logic       tx_stb;
  logic [7:0] tx_dat;
  logic       tx_rdy = 1;
  logic [7:0] ctl;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q [$];
  logic [7:0] mem [16];
  logic [7:0] e;

  serial_responder #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_err(rx_err),
    .rx_rdy(rx_rdy), .tx_stb(tx_stb), .tx_dat(tx_dat), .tx_rdy(tx_rdy), .ctl(ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && tx_stb && tx_rdy) begin
      if (q.size() == 0) check("spurious_tx", tx_stb, 0);
      else begin
        e = q.pop_front();
        check("tx_dat", tx_dat, e);
      end
    end

  task automatic send(input logic [7:0] d, input logic er, input logic rsp, input logic [7:0] exp);
    int n = 0;
    @(posedge clk); #1;
    rx_stb = 1; rx_dat = d; rx_err = er;
    while (!rx_rdy && n < 200) begin @(posedge clk); #1; n++; end
    if (n == 200) check("rx_rdy_wait", rx_rdy, 1);
    if (rsp) q.push_back(exp);
    @(posedge clk); #1;
    rx_stb = 0; rx_err = 0;
    check("tx_stb_latency", tx_stb, rsp);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain", q.size(), 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    send({4'h8, a}, 0, 0, 0);
    send(v, 0, 1, 8'hAA);
    mem[a] = v;
  endtask

  task automatic rd(input logic [3:0] a);
    send({4'h0, a}, 0, 1, mem[a]);
  endtask

  task automatic do_reset();
    #3 rst = 0;
    #1;
    check("rst_tx_stb", tx_stb, 0);
    check("rst_rx_rdy", rx_rdy, 1);
    check("rst_ctl", ctl, 0);
    check("rst_tx_dat", tx_dat, 0);
    q.delete();
    for (int i = 0; i < 16; i++) mem[i] = 0;
    @(posedge clk); #2 rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    do_reset();
    // write-read
    wr(3, 8'h5A);
    rd(3);
    drain();
    // control output
    wr(0, 8'hC3);
    check("ctl_after_wr", ctl, 8'hC3);
    drain();
    do_reset();
    rd(3);
    drain();
    // error paths
    send(8'h30, 0, 1, 8'hEE);
    send(8'hF0, 0, 1, 8'hEE);
    send(8'h85, 1, 1, 8'hEE);
    send(8'h85, 0, 0, 0);
    send(8'h12, 1, 1, 8'hEE);
    rd(5);
    drain();
    // timeout: full expiry, then byte on expiry cycle dropped, then byte just before accepted
    send(8'h85, 0, 0, 0);
    repeat (101) @(posedge clk);
    check("tmo_no_tx", tx_stb, 0);
    rd(5);
    drain();
    send(8'h86, 0, 0, 0);
    repeat (99) @(posedge clk);
    send(8'h44, 0, 0, 0);
    rd(6);
    drain();
    send(8'h87, 0, 0, 0);
    repeat (98) @(posedge clk);
    send(8'h77, 0, 1, 8'hAA);
    mem[7] = 8'h77;
    rd(7);
    drain();
    // backpressure with ignored strobes
    wr(3, 8'h5A);
    drain();
    tx_rdy = 0;
    rd(3);
    begin
      int bad = 0;
      rx_stb = 1; rx_dat = 8'h89;
      repeat (50) begin
        @(negedge clk);
        if (!(tx_stb === 1 && tx_dat === 8'h5A && rx_rdy === 0)) bad++;
      end
      check("bp_hold", bad, 0);
      rx_stb = 0;
    end
    check("bp_pending", q.size(), 1);
    @(posedge clk); #1 tx_rdy = 1;
    drain();
    @(posedge clk); #1;
    check("bp_idle_stb", tx_stb, 0);
    check("bp_idle_rdy", rx_rdy, 1);
    rd(9);
    drain();
    // reset mid-response drops tx_stb asynchronously
    tx_rdy = 0;
    rd(3);
    @(posedge clk);
    do_reset();
    tx_rdy = 1;
    rd(3);
    drain();
    // reset mid-frame discards partial write; next byte is a command
    send(8'h84, 0, 0, 0);
    do_reset();
    send(8'h04, 0, 1, 8'h00);
    drain();
    // random write/read pairs
    for (int k = 0; k < 8; k++) begin
      logic [3:0] a;
      logic [7:0] v;
      a = 4'($urandom_range(0, 15));
      v = 8'($urandom_range(0, 255));
      wr(a, v);
      rd(a);
      if (a == 0) check("ctl_rand", ctl, v);
    end
    drain();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_responder.md
SERIAL_RESPONDER -- requirements
Module: serial_responder

Interface
REQ-001 Parameter TIMEOUT, default 65535, is the maximum number of clk cycles the block waits for a write data byte before abandoning the frame.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 rx_stb  input  1  byte-valid strobe from the receive block.
REQ-005 rx_dat  input  8  received byte; qualified by rx_stb.
REQ-006 rx_err  input  1  framing error flag for the byte on rx_dat; qualified by rx_stb.
REQ-007 rx_rdy  output  1  responder can accept a received byte.
REQ-008 tx_stb  output  1  response byte valid, toward the transmit block.
REQ-009 tx_dat  output  8  response byte.
REQ-010 tx_rdy  input  1  transmit block accepts tx_dat.
REQ-011 ctl  output  8  continuous copy of register 0.

Function
REQ-012 The block SHALL hold a 16 x 8-bit register file, addressed 0..15.
REQ-013 A byte is accepted only on a cycle with rx_stb=1 and rx_rdy=1; a response byte is consumed only on a cycle with tx_stb=1 and tx_rdy=1.
REQ-014 Command byte format: bit7 = write(1)/read(0); bits 6:4 must be 000; bits 3:0 = address.
REQ-015 FSM states: IDLE, DATA, RESP; rx_rdy=1 in IDLE and DATA, 0 in RESP; tx_stb=1 only in RESP.
REQ-016 IDLE, accepted byte with rx_err=1: go to RESP with tx_dat=0xEE.
REQ-017 IDLE, accepted valid read command: go to RESP with tx_dat = register[address], sampled at acceptance.
REQ-018 IDLE, accepted valid write command: latch address, clear timer, go to DATA.
REQ-019 IDLE, accepted byte with bits 6:4 nonzero: go to RESP with tx_dat=0xEE; no register changes.
REQ-020 DATA, accepted byte with rx_err=0: write it to the latched address, go to RESP with tx_dat=0xAA.
REQ-021 DATA, accepted byte with rx_err=1: no write; go to RESP with tx_dat=0xEE.
REQ-022 DATA: the timer increments each cycle with no accepted byte. When it reaches TIMEOUT, go to IDLE with no response and no write. A byte accepted on that same cycle is discarded.
REQ-023 tx_stb SHALL assert on the clock edge that accepts the final frame byte, giving one cycle of latency.
REQ-024 In RESP, tx_dat and tx_stb are held stable until consumed. Consumption returns the FSM to IDLE on that edge.
REQ-025 A register write is visible on ctl (address 0) and to reads from the cycle after the data byte is accepted; a read of the just-written address returns the new value.
REQ-026 rx_stb in RESP is ignored; the byte is neither buffered nor acted upon.
REQ-027 The timer SHALL saturate and never wrap; its width is $clog2(TIMEOUT+1).

Reset
REQ-028 While rst=0: state=IDLE, all registers=0x00, ctl=0x00, tx_stb=0, tx_dat=0x00, timer=0, latched address=0, rx_rdy=1.
REQ-029 Reset asserted mid-frame or mid-response SHALL drop tx_stb immediately, asynchronously, and discard the partial frame.
REQ-030 The first byte accepted after reset release SHALL be treated as a command.

Verification
REQ-031 Write-read: send 0x83, then 0x5A, then 0x03 -> responses 0xAA, then 0x5A.
REQ-032 Control output: send 0x80, then 0xC3 -> response 0xAA; ctl=0xC3 one cycle after acceptance; after rst pulse, ctl=0x00.
REQ-033 Error paths: send 0x30 -> 0xEE; send any byte with rx_err=1 -> 0xEE; a following read of 0x05 returns 0x00.
REQ-034 Timeout, TIMEOUT=100: send 0x85, idle 101 cycles -> no tx_stb; then send 0x05 -> response 0x00.
REQ-035 Backpressure: hold tx_rdy=0 for 50 cycles after a read -> tx_stb stays 1, tx_dat stable, rx_rdy=0; strobes sent meanwhile are ignored; release tx_rdy -> one consume, then IDLE.
REQ-036 Loopback: connect to receive/transmit at BAUD 9600, FREQ 12 MHz; run 8 random write/read pairs over serial -> every read returns its written value, with no rx_err.
